// File: rtl/receptor_pedidos_serial_pkg.sv
// -----------------------------------------------------------------------------
// smart_cargo_defs
// Shared definitions for the SmartCargo serial request receiver:
//   - byte field positions (control flag, pulse bits, request slices)
//   - empty object type code
//   - receiver FSM encodings
//   - request record type and small decode helpers
// -----------------------------------------------------------------------------
package smart_cargo_defs;

    // Control byte: bit7 set, pulse request bits below
    localparam int unsigned BIT_CONTROLE   = 7;
    localparam int unsigned BIT_INICIAR    = 0;
    localparam int unsigned BIT_RESET      = 2;
    localparam int unsigned BIT_EMERGENCIA = 4;

    // Request byte slices (bit6 is don't-care)
    localparam int unsigned TIPO_MSB    = 5;
    localparam int unsigned TIPO_LSB    = 4;
    localparam int unsigned DESTINO_MSB = 3;
    localparam int unsigned DESTINO_LSB = 2;
    localparam int unsigned ORIGEM_MSB  = 1;
    localparam int unsigned ORIGEM_LSB  = 0;

    localparam logic [1:0] TIPO_VAZIO = 2'b00;

    // Width of one stored request {tipo, destino, origem}
    localparam int unsigned LARG_PEDIDO = 6;

    typedef enum logic [1:0] {
        ESPERA     = 2'b00,
        DECODIFICA = 2'b01
    } estado_t;

    typedef struct packed {
        logic [1:0] tipo;
        logic [1:0] destino;
        logic [1:0] origem;
    } pedido_t;

    function automatic pedido_t extrai_pedido(input logic [7:0] b);
        pedido_t p;
        p.tipo    = b[TIPO_MSB:TIPO_LSB];
        p.destino = b[DESTINO_MSB:DESTINO_LSB];
        p.origem  = b[ORIGEM_MSB:ORIGEM_LSB];
        return p;
    endfunction

    function automatic logic pedido_bem_formado(input pedido_t p);
        return (p.tipo != TIPO_VAZIO) && (p.origem != p.destino);
    endfunction

endpackage

// File: rtl/receptor_pedidos_serial_fifo.sv
// -----------------------------------------------------------------------------
// fifo_pedidos
// Small first-word-fall-through FIFO holding decoded requests.
// Ports:
//   clock, reset      rising-edge clock, async active-high reset
//   push, dado_in     write request (honoured when not full, or full with pop)
//   pop               consume head (ignored while empty)
//   dado_out          head entry, read combinationally from the read slot
//   cheia, vazia      full / empty flags
//   ocupacao          number of stored entries
// -----------------------------------------------------------------------------
module fifo_pedidos
    import smart_cargo_defs::*;
#(
    parameter int unsigned PROFUNDIDADE = 4,
    parameter int unsigned LARG_OCUP    = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [LARG_PEDIDO-1:0] dado_in,
    output logic [LARG_PEDIDO-1:0] dado_out,
    output logic                   cheia,
    output logic                   vazia,
    output logic [LARG_OCUP-1:0]   ocupacao
);

    localparam int unsigned LARG_PTR = $clog2(PROFUNDIDADE);

    logic [LARG_PEDIDO-1:0] mem [PROFUNDIDADE];
    logic [LARG_PTR-1:0]    ptr_escrita;
    logic [LARG_PTR-1:0]    ptr_leitura;
    logic                   pop_ef;
    logic                   push_ef;

    assign vazia    = (ocupacao == '0);
    assign cheia    = (ocupacao == LARG_OCUP'(PROFUNDIDADE));
    assign dado_out = mem[ptr_leitura];

    // When full, a simultaneous pop frees the slot the write lands in
    assign pop_ef  = pop & ~vazia;
    assign push_ef = push & (~cheia | pop_ef);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_escrita <= '0;
            ptr_leitura <= '0;
            ocupacao    <= '0;
            for (int unsigned i = 0; i < PROFUNDIDADE; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ef) begin
                mem[ptr_escrita] <= dado_in;
                ptr_escrita      <= ptr_escrita + LARG_PTR'(1);
            end
            if (pop_ef) begin
                ptr_leitura <= ptr_leitura + LARG_PTR'(1);
            end
            case ({push_ef, pop_ef})
                2'b10:   ocupacao <= ocupacao + LARG_OCUP'(1);
                2'b01:   ocupacao <= ocupacao - LARG_OCUP'(1);
                default: ocupacao <= ocupacao;
            endcase
        end
    end

endmodule

// File: rtl/receptor_pedidos_serial.sv
// -----------------------------------------------------------------------------
// receptor_pedidos_serial
// Consumes bytes from the 8N1 UART receiver, turns control bytes into
// one-cycle command pulses and queues validated request bytes for the
// SmartCargo datapath.
// Optional feature macro: REJEITA_DUPLICADO_EN -- when defined, a valid
// request equal to the last pushed one is dropped silently.
// Ports:
//   clock, reset                  clock / async active-high reset
//   pronto_rx, dados_rx           UART byte ready (level) and byte
//   pedido_ack                    datapath consumed head request
//   pedido_valido                 FIFO non-empty, head fields valid
//   pedido_origem/destino/tipo    head request fields
//   iniciar/reset/emergencia_serial  one-cycle command pulses
//   erro_pedido                   one-cycle pulse on rejected request
//   fila_cheia, db_ocupacao       full flag / occupancy
//   db_estado                     FSM state encoding
// -----------------------------------------------------------------------------
module receptor_pedidos_serial
    import smart_cargo_defs::*;
#(
    parameter int unsigned PROFUNDIDADE = 4,
    parameter int unsigned LARG_OCUP    = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pronto_rx,
    input  logic [7:0]           dados_rx,
    input  logic                 pedido_ack,
    output logic                 pedido_valido,
    output logic [1:0]           pedido_origem,
    output logic [1:0]           pedido_destino,
    output logic [1:0]           pedido_tipo,
    output logic                 iniciar_serial,
    output logic                 reset_serial,
    output logic                 emergencia_serial,
    output logic                 erro_pedido,
    output logic                 fila_cheia,
    output logic [LARG_OCUP-1:0] db_ocupacao,
    output logic [1:0]           db_estado
);

    estado_t              estado;
    estado_t              prox_estado;
    logic                 pronto_rx_q;
    logic                 borda;
    logic [7:0]           byte_reg;

    pedido_t              pedido;
    pedido_t              cabeca;
    logic                 decodificando;
    logic                 controle;
    logic                 pedido_ok;
    logic                 duplicado;
    logic                 pop;
    logic                 cabe;
    logic                 push;
    logic                 erro_d;
    logic                 vazia;
    logic                 cheia;
    logic [LARG_OCUP-1:0] ocupacao;
    logic                 bit6_unused;

    assign borda       = pronto_rx & ~pronto_rx_q;
    assign bit6_unused = byte_reg[6];

    // ---------------- state register, edge register, byte latch -----------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado      <= ESPERA;
            pronto_rx_q <= 1'b0;
            byte_reg    <= '0;
        end else begin
            estado      <= prox_estado;
            pronto_rx_q <= pronto_rx;
            if (estado == ESPERA && borda) begin
                byte_reg <= dados_rx;
            end
        end
    end

    // ---------------- next state and decode ---------------------------------
    always_comb begin
        prox_estado   = ESPERA;
        decodificando = 1'b0;
        case (estado)
            ESPERA: begin
                if (borda) prox_estado = DECODIFICA;
            end
            DECODIFICA: begin
                decodificando = 1'b1;
                prox_estado   = ESPERA;
            end
            default: prox_estado = ESPERA;
        endcase
    end

    assign controle  = byte_reg[BIT_CONTROLE];
    assign pedido    = extrai_pedido(byte_reg);
    assign pedido_ok = pedido_bem_formado(pedido);
    assign pop       = ~vazia & pedido_ack;
    assign cabe      = ~cheia | pop;

    // Duplicates are a silent drop, so they never raise erro_pedido even
    // when the queue has no room.
    assign push   = decodificando & ~controle & pedido_ok & ~duplicado & cabe;
    assign erro_d = decodificando & ~controle &
                    (~pedido_ok | (~duplicado & ~cabe));

`ifdef REJEITA_DUPLICADO_EN
    pedido_t ultimo;
    logic    ultimo_valido;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ultimo        <= '0;
            ultimo_valido <= 1'b0;
        end else if (push) begin
            ultimo        <= pedido;
            ultimo_valido <= 1'b1;
        end else if (pop && ocupacao == LARG_OCUP'(1)) begin
            // queue drains to empty on this edge
            ultimo_valido <= 1'b0;
        end
    end

    assign duplicado = ultimo_valido && (ultimo == pedido);
`else
    assign duplicado = 1'b0;
`endif

    // ---------------- pulse registers ---------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            iniciar_serial    <= 1'b0;
            reset_serial      <= 1'b0;
            emergencia_serial <= 1'b0;
            erro_pedido       <= 1'b0;
        end else begin
            iniciar_serial    <= decodificando & controle & byte_reg[BIT_INICIAR];
            reset_serial      <= decodificando & controle & byte_reg[BIT_RESET];
            emergencia_serial <= decodificando & controle & byte_reg[BIT_EMERGENCIA];
            erro_pedido       <= erro_d;
        end
    end

    // ---------------- request queue -----------------------------------------
    fifo_pedidos #(
        .PROFUNDIDADE (PROFUNDIDADE),
        .LARG_OCUP    (LARG_OCUP)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .dado_in  (pedido),
        .dado_out (cabeca),
        .cheia    (cheia),
        .vazia    (vazia),
        .ocupacao (ocupacao)
    );

    assign pedido_valido  = ~vazia;
    assign pedido_origem  = cabeca.origem;
    assign pedido_destino = cabeca.destino;
    assign pedido_tipo    = cabeca.tipo;
    assign fila_cheia     = cheia;
    assign db_ocupacao    = ocupacao;
    assign db_estado      = estado;

endmodule

// File: tb/tb_receptor_pedidos_serial.sv
module tb_receptor_pedidos_serial;

    logic       clock = 1'b0;
    logic       reset;
    logic       pronto_rx;
    logic [7:0] dados_rx;
    logic       pedido_ack;
    logic       pedido_valido;
    logic [1:0] pedido_origem;
    logic [1:0] pedido_destino;
    logic [1:0] pedido_tipo;
    logic       iniciar_serial;
    logic       reset_serial;
    logic       emergencia_serial;
    logic       erro_pedido;
    logic       fila_cheia;
    logic [2:0] db_ocupacao;
    logic [1:0] db_estado;

    int total = 0;
    int bad   = 0;

    // pulse / sample records filled by send_byte
    int   n_err, n_ini, n_rst, n_emg, n_all3;
    logic v_n1, v_n2;
    logic [1:0] st_n1;

    logic [5:0] sb[$];

    always #5 clock = ~clock;

    receptor_pedidos_serial #(
        .PROFUNDIDADE (4),
        .LARG_OCUP    (3)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .pronto_rx         (pronto_rx),
        .dados_rx          (dados_rx),
        .pedido_ack        (pedido_ack),
        .pedido_valido     (pedido_valido),
        .pedido_origem     (pedido_origem),
        .pedido_destino    (pedido_destino),
        .pedido_tipo       (pedido_tipo),
        .iniciar_serial    (iniciar_serial),
        .reset_serial      (reset_serial),
        .emergencia_serial (emergencia_serial),
        .erro_pedido       (erro_pedido),
        .fila_cheia        (fila_cheia),
        .db_ocupacao       (db_ocupacao),
        .db_estado         (db_estado)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raise pronto_rx with byte b for 'hold' cycles (hold >= 2) and record
    // pulses seen over the following window.
    task automatic send_byte(input logic [7:0] b, input int hold);
        n_err = 0; n_ini = 0; n_rst = 0; n_emg = 0; n_all3 = 0;
        @(negedge clock);
        pronto_rx = 1'b1;
        dados_rx  = b;
        for (int i = 0; i < hold + 3; i++) begin
            @(negedge clock);
            if (i == 0) begin
                v_n1  = pedido_valido;
                st_n1 = db_estado;
            end
            if (i == 1) v_n2 = pedido_valido;
            n_err  += int'(erro_pedido);
            n_ini  += int'(iniciar_serial);
            n_rst  += int'(reset_serial);
            n_emg  += int'(emergencia_serial);
            n_all3 += int'(iniciar_serial & reset_serial & emergencia_serial);
            if (i == hold - 1) pronto_rx = 1'b0;
        end
    endtask

    task automatic do_ack(input string tag);
        logic [5:0] exp;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp = sb.pop_front();
            chk({tag, "_valido"}, {31'd0, pedido_valido}, 32'd1);
            chk({tag, "_cabeca"}, {26'd0, pedido_tipo, pedido_destino, pedido_origem},
                {26'd0, exp});
        end
        pedido_ack = 1'b1;
        @(negedge clock);
        pedido_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        sb.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        pronto_rx  = 1'b0;
        dados_rx   = '0;
        pedido_ack = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // ---- reset state
        chk("rst_valido", {31'd0, pedido_valido}, 32'd0);
        chk("rst_ocup",   {29'd0, db_ocupacao}, 32'd0);
        chk("rst_cheia",  {31'd0, fila_cheia}, 32'd0);
        chk("rst_estado", {30'd0, db_estado}, 32'd0);
        chk("rst_pulsos", {28'd0, iniciar_serial, reset_serial, emergencia_serial, erro_pedido}, 32'd0);

        // ---- held pronto_rx, single request 0x19
        send_byte(8'h19, 5);
        sb.push_back(6'h19);
        chk("p1_valido_borda1", {31'd0, v_n1}, 32'd0);
        chk("p1_estado_decod",  {30'd0, st_n1}, 32'd1);
        chk("p1_valido_borda2", {31'd0, v_n2}, 32'd1);
        chk("p1_ocup",   {29'd0, db_ocupacao}, 32'd1);
        chk("p1_origem", {30'd0, pedido_origem}, 32'd1);
        chk("p1_destino",{30'd0, pedido_destino}, 32'd2);
        chk("p1_tipo",   {30'd0, pedido_tipo}, 32'd1);
        chk("p1_erro",   n_err, 32'd0);

        // ---- invalid requests
        send_byte(8'h15, 2);
        chk("inv_orig_dest_erro", n_err, 32'd1);
        chk("inv_orig_dest_ocup", {29'd0, db_ocupacao}, 32'd1);
        send_byte(8'h05, 2);
        chk("inv_tipo_erro", n_err, 32'd1);
        chk("inv_tipo_ocup", {29'd0, db_ocupacao}, 32'd1);

        // ---- control byte
        send_byte(8'h95, 3);
        chk("ctl_ini",  n_ini, 32'd1);
        chk("ctl_rst",  n_rst, 32'd1);
        chk("ctl_emg",  n_emg, 32'd1);
        chk("ctl_all3", n_all3, 32'd1);
        chk("ctl_erro", n_err, 32'd0);
        chk("ctl_ocup", {29'd0, db_ocupacao}, 32'd1);

        @(negedge clock);
        do_ack("ack_p1");
        chk("ack_p1_vazio", {31'd0, pedido_valido}, 32'd0);

        // ---- fill to full, then overflow
        send_byte(8'h19, 2); sb.push_back(6'h19);
        send_byte(8'h24, 2); sb.push_back(6'h24);
        send_byte(8'h36, 2); sb.push_back(6'h36);
        chk("fill3_cheia", {31'd0, fila_cheia}, 32'd0);
        send_byte(8'h1B, 2); sb.push_back(6'h1B);
        chk("fill4_cheia", {31'd0, fila_cheia}, 32'd1);
        chk("fill4_ocup",  {29'd0, db_ocupacao}, 32'd4);
        send_byte(8'h2E, 2);
        chk("over_erro",  n_err, 32'd1);
        chk("over_ocup",  {29'd0, db_ocupacao}, 32'd4);

        // ---- full, decode coincides with ack
        @(negedge clock);
        pronto_rx = 1'b1;
        dados_rx  = 8'h31;
        @(negedge clock);
        do_ack("sim_ack");
        chk("sim_erro", {31'd0, erro_pedido}, 32'd0);
        chk("sim_ocup", {29'd0, db_ocupacao}, 32'd4);
        sb.push_back(6'h31);
        pronto_rx = 1'b0;
        repeat (2) @(negedge clock);
        chk("sim_erro_late", {31'd0, erro_pedido}, 32'd0);

        // ---- drain in order
        do_ack("drain0");
        do_ack("drain1");
        do_ack("drain2");
        do_ack("drain3");
        chk("drain_vazio", {31'd0, pedido_valido}, 32'd0);
        chk("drain_ocup",  {29'd0, db_ocupacao}, 32'd0);

        // ---- ack while empty is ignored
        pedido_ack = 1'b1;
        @(negedge clock);
        pedido_ack = 1'b0;
        chk("ack_vazio_ocup", {29'd0, db_ocupacao}, 32'd0);

        // ---- async reset with 3 queued
        send_byte(8'h19, 2);
        send_byte(8'h24, 2);
        send_byte(8'h36, 2);
        chk("pre_rst_ocup", {29'd0, db_ocupacao}, 32'd3);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("async_rst_valido", {31'd0, pedido_valido}, 32'd0);
        chk("async_rst_ocup",   {29'd0, db_ocupacao}, 32'd0);
        sb.delete();
        @(negedge clock);
        reset = 1'b0;

        // ---- duplicate handling
        send_byte(8'h19, 2);
        send_byte(8'h19, 2);
        chk("dup_erro", n_err, 32'd0);
`ifdef REJEITA_DUPLICADO_EN
        chk("dup_ocup", {29'd0, db_ocupacao}, 32'd1);
`else
        chk("dup_ocup", {29'd0, db_ocupacao}, 32'd2);
`endif

        do_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
